imm_enc: RTL and testbench

- Instruction encoder: the inverse of the immediate decode path.
- Accepts decoded fields (format, registers, funct3, 64-bit immediate) and packs them into a 32-bit RV64 instruction word for the I-load, I-ALU, S and B formats.
- Range-checks the immediate, then streams words with a running byte address toward instruction-memory load logic.
- Two-stage valid/ready pipeline with full backpressure.

---
 rtl/imm_enc_pkg.sv | 19 +
 rtl/imm_pack.sv | 42 ++++
 rtl/imm_enc.sv | 137 +++++++++++++
 tb/tb_imm_enc.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_enc_pkg.sv
// Shared constants for the immediate encoder: format codes, opcodes and widths.
package imm_enc_pkg;

    typedef enum logic [1:0] {
        FMT_I_LD  = 2'd0,
        FMT_I_ALU = 2'd1,
        FMT_S     = 2'd2,
        FMT_B     = 2'd3
    } fmt_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_ALU_I  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam int unsigned INS_W = 32;
    localparam int unsigned IMM_W = 64;

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: decoded fields to a 32-bit RV64 word plus immediate range error.
// IMM_SEXT_EN selects the signed range check; packing is the same in both builds.
module imm_pack
    import imm_enc_pkg::*;
(
    input  logic [1:0]       fmt,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [IMM_W-1:0] imm,
    output logic [INS_W-1:0] ins,
    output logic             err
);

    always_comb begin
        ins = '0;
        err = 1'b0;
        unique case (fmt_e'(fmt))
            FMT_I_LD:  ins = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
            FMT_I_ALU: ins = {imm[11:0], rs1, funct3, rd, OPC_ALU_I};
            FMT_S:     ins = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
            FMT_B:     ins = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
        endcase

        // Branch offsets carry one extra magnitude bit and must be halfword aligned.
        if (fmt_e'(fmt) == FMT_B) begin
`ifdef IMM_SEXT_EN
            err = !((~|imm[63:12]) || (&imm[63:12])) || imm[0];
`else
            err = (|imm[63:13]) || imm[0];
`endif
        end else begin
`ifdef IMM_SEXT_EN
            err = !((~|imm[63:11]) || (&imm[63:11]));
`else
            err = |imm[63:12];
`endif
        end
    end

endmodule

// File: rtl/imm_enc.sv
// Two-stage valid/ready instruction encoder with a running output byte address.
// Build option: IMM_SEXT_EN (signed immediate range check, see imm_pack).
module imm_enc
    import imm_enc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [IMM_W-1:0]  imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INS_W-1:0]  ins,
    output logic [ADDR_W-1:0] out_addr,
    output logic              range_err
);

    logic              s1_valid_q, s1_valid_d;
    logic [1:0]        s1_fmt_q, s1_fmt_d;
    logic [4:0]        s1_rd_q, s1_rd_d;
    logic [4:0]        s1_rs1_q, s1_rs1_d;
    logic [4:0]        s1_rs2_q, s1_rs2_d;
    logic [2:0]        s1_funct3_q, s1_funct3_d;
    logic [IMM_W-1:0]  s1_imm_q, s1_imm_d;

    logic              s2_valid_q, s2_valid_d;
    logic [INS_W-1:0]  s2_ins_q, s2_ins_d;
    logic              s2_err_q, s2_err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              s2_load;
    logic              in_fire;
    logic              out_fire;
    logic [INS_W-1:0]  pack_ins;
    logic              pack_err;

    imm_pack u_pack (
        .fmt    (s1_fmt_q),
        .rd     (s1_rd_q),
        .rs1    (s1_rs1_q),
        .rs2    (s1_rs2_q),
        .funct3 (s1_funct3_q),
        .imm    (s1_imm_q),
        .ins    (pack_ins),
        .err    (pack_err)
    );

    always_comb begin
        s2_load  = !s2_valid_q || out_ready;
        in_ready = (!s1_valid_q || s2_load) && !clr;
        in_fire  = in_valid && in_ready;
        out_fire = s2_valid_q && out_ready;

        s1_fmt_d    = s1_fmt_q;
        s1_rd_d     = s1_rd_q;
        s1_rs1_d    = s1_rs1_q;
        s1_rs2_d    = s1_rs2_q;
        s1_funct3_d = s1_funct3_q;
        s1_imm_d    = s1_imm_q;
        s2_valid_d  = s2_valid_q;
        s2_ins_d    = s2_ins_q;
        s2_err_d    = s2_err_q;
        addr_d      = addr_q;

        if (in_fire) begin
            s1_fmt_d    = fmt;
            s1_rd_d     = rd;
            s1_rs1_d    = rs1;
            s1_rs2_d    = rs2;
            s1_funct3_d = funct3;
            s1_imm_d    = imm;
        end
        s1_valid_d = in_fire || (s1_valid_q && !s2_load);

        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_ins_d = pack_ins;
                s2_err_d = pack_err;
            end
        end

        if (out_fire) begin
            addr_d = addr_q + ADDR_W'(4);
        end

        // Flush wins over any handshake in the same cycle.
        if (clr) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            addr_d     = BASE_ADDR;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_fmt_q    <= '0;
            s1_rd_q     <= '0;
            s1_rs1_q    <= '0;
            s1_rs2_q    <= '0;
            s1_funct3_q <= '0;
            s1_imm_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_ins_q    <= '0;
            s2_err_q    <= 1'b0;
            addr_q      <= BASE_ADDR;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_fmt_q    <= s1_fmt_d;
            s1_rd_q     <= s1_rd_d;
            s1_rs1_q    <= s1_rs1_d;
            s1_rs2_q    <= s1_rs2_d;
            s1_funct3_q <= s1_funct3_d;
            s1_imm_q    <= s1_imm_d;
            s2_valid_q  <= s2_valid_d;
            s2_ins_q    <= s2_ins_d;
            s2_err_q    <= s2_err_d;
            addr_q      <= addr_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign ins       = s2_ins_q;
    assign range_err = s2_err_q;
    assign out_addr  = addr_q;

endmodule

// File: tb/tb_imm_enc.sv
// Self-checking bench for imm_enc: directed steps plus randomized traffic against a reference model.
module tb_imm_enc;

    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    fmt;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [2:0]    funct3;
    logic [63:0]   imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   ins;
    logic [AW-1:0] out_addr;
    logic          range_err;

    int errors = 0;
    int checks = 0;

    logic [32:0]   sb[$];
    logic [AW-1:0] addr_log[$];
    int unsigned   exp_addr;
    logic          prev_stall;
    logic [31:0]   prev_ins;
    logic [63:0]   bnd[10];

    always #5 clk = ~clk;

    imm_enc #(.ADDR_W(AW), .BASE_ADDR(AW'(0))) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ins       (ins),
        .out_addr  (out_addr),
        .range_err (range_err)
    );

    // Reference: {err, word} from the field layouts and plain range arithmetic.
    function automatic logic [32:0] ref_enc(input logic [1:0] f, input logic [4:0] d,
                                            input logic [4:0] a, input logic [4:0] b,
                                            input logic [2:0] f3, input logic [63:0] im);
        logic [6:0]         opc;
        logic [31:0]        w;
        logic               e;
        logic signed [63:0] si;
        si = im;
        case (f)
            2'd0:    opc = 7'h03;
            2'd1:    opc = 7'h13;
            2'd2:    opc = 7'h23;
            default: opc = 7'h63;
        endcase
        if (f < 2'd2)       w = {im[11:0], a, f3, d, opc};
        else if (f == 2'd2) w = {im[11:5], b, a, f3, im[4:0], opc};
        else                w = {im[12], im[10:5], b, a, f3, im[4:1], im[11], opc};
`ifdef IMM_SEXT_EN
        if (f == 2'd3) e = (si < -64'sd4096) || (si > 64'sd4095) || im[0];
        else           e = (si < -64'sd2048) || (si > 64'sd2047);
`else
        if (f == 2'd3) e = (im >= 64'd8192) || im[0];
        else           e = (im >= 64'd4096);
`endif
        return {e, w};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        exp_addr   = 0;
        prev_stall = 1'b0;
    endtask

    task automatic reset_checks();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_ins", ins, 0);
        chk("rst_range_err", range_err, 0);
        chk("rst_out_addr", out_addr, 0);
    endtask

    // One clock: settle, check against the model, update the model, advance to edge+1.
    task automatic cycle(output logic fired);
        logic exp_rdy;
        #1;
        exp_rdy = !clr && ((sb.size() < 2) || out_ready);
        chk("in_ready", in_ready, exp_rdy);
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_ins", ins, prev_ins);
        end
        if (sb.size() == 0) begin
            chk("idle_valid", out_valid, 0);
        end else if (out_valid) begin
            chk("ins", ins, sb[0][31:0]);
            chk("range_err", range_err, sb[0][32]);
            chk("out_addr", out_addr, 64'(exp_addr));
        end
        fired      = in_valid && in_ready;
        prev_stall = out_valid && !out_ready && !clr;
        prev_ins   = ins;
        if (clr) begin
            sb.delete();
            exp_addr = 0;
        end else begin
            if (out_valid && out_ready) begin
                addr_log.push_back(out_addr);
                if (sb.size() > 0) void'(sb.pop_front());
                exp_addr = (exp_addr + 4) % 16;
            end
            if (fired) sb.push_back(ref_enc(fmt, rd, rs1, rs2, funct3, imm));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] f, input logic [4:0] d, input logic [4:0] a,
                        input logic [4:0] b, input logic [2:0] f3, input logic [63:0] im);
        logic acc;
        acc = 1'b0;
        fmt = f; rd = d; rs1 = a; rs2 = b; funct3 = f3; imm = im;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) cycle(acc);
        if (!acc) chk("send_timeout", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        logic f;
        for (int k = 0; k < 10 && !out_valid; k++) cycle(f);
        chk("wait_out_valid", out_valid, 1);
    endtask

    task automatic idle(input int n);
        logic f;
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) cycle(f);
    endtask

    initial begin
        logic        f;
        logic [32:0] r;
        int          acc_cnt;
        int          sent;
        logic [1:0]  bp_fmt[4];
        logic [63:0] bp_imm[4];
        logic [AW-1:0] wrap_exp[5];

        bnd[0] = 64'd2047;  bnd[1] = 64'd2048;  bnd[2] = 64'd4095;  bnd[3] = 64'd4096;
        bnd[4] = 64'd8191;  bnd[5] = 64'd8192;  bnd[6] = -64'd2048; bnd[7] = -64'd2049;
        bnd[8] = -64'd4096; bnd[9] = -64'd4097;
        wrap_exp[0] = 4'd0; wrap_exp[1] = 4'd4; wrap_exp[2] = 4'd8; wrap_exp[3] = 4'd12; wrap_exp[4] = 4'd0;

        reset_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        fmt = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; imm = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_checks();
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // I-load latency: two edges from handshake to out_valid.
        out_ready = 1'b1;
        send(2'd0, 5'd5, 5'd2, 5'd9, 3'd3, 64'd8);
        chk("ld_lat1_valid", out_valid, 0);
        idle(1);
        chk("ld_valid", out_valid, 1);
        chk("ld_ins", ins, 32'h00813283);
        chk("ld_err", range_err, 0);
        chk("ld_addr", out_addr, 0);

        send(2'd2, 5'd7, 5'd2, 5'd5, 3'd3, 64'd16);
        wait_out();
        chk("s_ins", ins, 32'h00513823);
        send(2'd3, 5'd7, 5'd1, 5'd2, 3'd0, 64'd8);
        wait_out();
        chk("b_ins", ins, 32'h00208463);

        send(2'd1, 5'd1, 5'd3, 5'd0, 3'd0, 64'h1000);
        wait_out();
        chk("rng_i_err", range_err, 1);
        chk("rng_i_hi", 64'(ins[31:20]), 0);
        send(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 64'd5);
        wait_out();
        chk("rng_b_odd_err", range_err, 1);
        send(2'd1, 5'd4, 5'd6, 5'd0, 3'd0, '1);
        wait_out();
        r = ref_enc(2'd1, 5'd4, 5'd6, 5'd0, 3'd0, '1);
        chk("neg1_err", range_err, r[32]);
        chk("neg1_hi", 64'(ins[31:20]), 12'hFFF);
        idle(2);

        // Backpressure: four back-to-back words against a stalled consumer.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bp_fmt[i] = 2'(i);
            bp_imm[i] = 64'(4 * i + 2);
        end
        acc_cnt = 0;
        sent = 0;
        for (int c = 0; c < 6; c++) begin
            fmt = bp_fmt[sent]; rd = 5'(sent + 1); rs1 = 5'(sent + 10); rs2 = 5'(sent + 20);
            funct3 = 3'(sent); imm = bp_imm[sent];
            in_valid = 1'b1;
            cycle(f);
            if (f) begin acc_cnt++; sent++; end
        end
        #1;
        chk("bp_held", 64'(acc_cnt), 2);
        chk("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk("bp_stream", out_valid, 1);
            if (sent < 4) begin
                fmt = bp_fmt[sent]; rd = 5'(sent + 1); rs1 = 5'(sent + 10); rs2 = 5'(sent + 20);
                funct3 = 3'(sent); imm = bp_imm[sent];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            cycle(f);
            if (f) sent++;
        end
        in_valid = 1'b0;
        chk("bp_all_sent", 64'(sent), 4);
        chk("bp_drained", 64'(sb.size()), 0);

        // Flush with two words in flight.
        out_ready = 1'b0;
        send(2'd0, 5'd1, 5'd1, 5'd1, 3'd1, 64'd4);
        send(2'd2, 5'd2, 5'd2, 5'd2, 3'd2, 64'd12);
        clr = 1'b1;
        #1;
        chk("clr_in_ready", in_ready, 0);
        cycle(f);
        clr = 1'b0;
        chk("clr_valid", out_valid, 0);
        chk("clr_addr", out_addr, 0);

        // Address wrap over five words.
        out_ready = 1'b1;
        addr_log.delete();
        for (int i = 0; i < 5; i++) send(2'd1, 5'(i), 5'(i), 5'd0, 3'd0, 64'(i));
        idle(4);
        chk("wrap_count", 64'(addr_log.size()), 5);
        for (int i = 0; i < 5 && i < addr_log.size(); i++) chk("wrap_addr", 64'(addr_log[i]), 64'(wrap_exp[i]));

        // Asynchronous reset in the middle of a stall.
        out_ready = 1'b0;
        send(2'd3, 5'd0, 5'd3, 5'd4, 3'd1, 64'd32);
        send(2'd2, 5'd0, 5'd5, 5'd6, 3'd2, 64'd40);
        idle(2);
        #2;
        reset_n = 1'b0;
        #1;
        reset_checks();
        model_reset();
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic with random backpressure and occasional flush.
        for (int c = 0; c < 400; c++) begin
            fmt = 2'($urandom_range(0, 3));
            rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); funct3 = 3'($urandom);
            case ($urandom_range(0, 3))
                0:       imm = 64'($urandom_range(0, 9000));
                1:       imm = -64'($urandom_range(1, 5000));
                2:       imm = {$urandom, $urandom};
                default: imm = bnd[$urandom_range(0, 9)];
            endcase
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clr       = ($urandom_range(0, 39) == 0);
            cycle(f);
        end
        clr = 1'b0;
        out_ready = 1'b1;
        idle(6);
        chk("final_drain", 64'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
